fifo_burst_reader: RTL

//  Read-side engine for the 8-bit sync FIFO: on a start command, pops exactly burst_len entries and

---
 rtl/fifo_burst_pkg.sv | 14 +
 rtl/fifo_skid_buf.sv | 49 ++++
 rtl/fifo_burst_reader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fifo_burst_pkg.sv
// Shared types and default widths for the FIFO burst reader.
package fifo_burst_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    CSUM
  } state_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry valid/ready output buffer; absorbs read data already requested from the FIFO
// while the consumer stalls. Exposes its occupancy so the reader can budget pops.
module fifo_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        held_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wrPtr_q, wrPtr_d;
  logic              rdPtr_q, rdPtr_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    wrPtr_d = push_i ? ~wrPtr_q : wrPtr_q;
    rdPtr_d = pop_i ? ~rdPtr_q : rdPtr_q;
    count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  // The reader never pushes into a full buffer or pops an empty one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wrPtr_q] <= data_i;
      end
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rdPtr_q];
  assign held_o  = count_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a burst of burst_len_i FIFO entries onto a valid/ready stream with m_last_o on the final beat.
// Define FIFO_RD_CSUM_EN to append an XOR checksum beat after the data beats.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  burst_len_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_rdata_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  readsLeft_q, readsLeft_d;
  logic [LEN_W-1:0]  beatsLeft_q, beatsLeft_d;
  logic              inflight_q;
  logic              done_q, done_d;

  logic              bufValid;
  logic [DATA_W-1:0] bufData;
  logic [1:0]        held;
  logic              bufPop;
  logic              rdEn;
  logic              finalDataHs;
  logic [2:0]        occupancy;

  fifo_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .data_i  (fifo_rdata_i),
    .pop_i   (bufPop),
    .valid_o (bufValid),
    .data_o  (bufData),
    .held_o  (held)
  );

  // A pop is only issued if its data is guaranteed a free buffer slot one cycle later.
  assign bufPop      = bufValid && m_ready_i;
  assign occupancy   = {1'b0, held} + {2'b00, inflight_q} - {2'b00, bufPop};
  assign rdEn        = (state_q == READ) && !fifo_empty_i &&
                       (readsLeft_q != '0) && (occupancy < 3'd2);
  assign finalDataHs = bufPop && (beatsLeft_q == LEN_W'(1));

`ifdef FIFO_RD_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && start_i) begin
      csum_d = '0;
    end else if (bufPop) begin
      csum_d = csum_q ^ bufData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      readsLeft_q <= '0;
      beatsLeft_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      readsLeft_q <= readsLeft_d;
      beatsLeft_q <= beatsLeft_d;
      inflight_q  <= rdEn;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    readsLeft_d = rdEn ? readsLeft_q - LEN_W'(1) : readsLeft_q;
    beatsLeft_d = bufPop ? beatsLeft_q - LEN_W'(1) : beatsLeft_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (burst_len_i != '0) begin
            state_d     = READ;
            readsLeft_d = burst_len_i;
            beatsLeft_d = burst_len_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (rdEn && readsLeft_q == LEN_W'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (finalDataHs) begin
`ifdef FIFO_RD_CSUM_EN
          state_d = CSUM;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef FIFO_RD_CSUM_EN
      CSUM: begin
        if (m_ready_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q != IDLE);
    done_o       = done_q;
    fifo_rd_en_o = rdEn;
    m_valid_o    = bufValid;
    m_data_o     = bufData;
`ifdef FIFO_RD_CSUM_EN
    m_last_o     = 1'b0;
    if (state_q == CSUM) begin
      m_valid_o = 1'b1;
      m_data_o  = csum_q;
      m_last_o  = 1'b1;
    end
`else
    m_last_o     = bufValid && (beatsLeft_q == LEN_W'(1));
`endif
  end

endmodule
